// File: rtl/jogador_automatico_pkg.sv
// Shared state codes, press sequence and verdict record for the automatic memory-game player.
package jogador_pkg;

   localparam logic [2:0] IDLE       = 3'd0;
   localparam logic [2:0] INICIA     = 3'd1;
   localparam logic [2:0] ESPERA_INI = 3'd2;
   localparam logic [2:0] PRESSIONA  = 3'd3;
   localparam logic [2:0] SOLTA      = 3'd4;
   localparam logic [2:0] AGUARDA    = 3'd5;
   localparam logic [2:0] FIM        = 3'd6;

   typedef struct packed {
      logic fim;
      logic passou;
      logic falhou;
   } veredito_t;

   function automatic logic [3:0] seq_valor(input logic [3:0] idx);
      return 4'b0001 << (idx & 4'd3);
   endfunction

   // Wrong press: one-hot value rotated left by one position.
   function automatic logic [3:0] rot_esq(input logic [3:0] v);
      return {v[2:0], v[3]};
   endfunction

endpackage

// File: rtl/jogador_automatico_temporizador.sv
// Loadable down-counter shared by every timed state; zero flags the last cycle of a state.
module temporizador #(
   parameter int W = 4
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         carga,
   input  logic         en,
   input  logic [W-1:0] valor,
   output logic         zero
);

   logic [W-1:0] conta;

   always_ff @(posedge clock or posedge reset) begin
      if (reset)                    conta <= '0;
      else if (carga)               conta <= valor;
      else if (en && conta != '0)   conta <= conta - 1'b1;
   end

   assign zero = (conta == '0);

endmodule

// File: rtl/jogador_automatico.sv
// Automatic player: drives iniciar/botoes through the memory game rounds and judges the outcome.
module jogador_automatico
   import jogador_pkg::*;
#(
   parameter int START_CYCLES   = 5,
   parameter int HOLD_CYCLES    = 10,
   parameter int GAP_CYCLES     = 10,
   parameter int N_JOGADAS      = 16,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       comecar,
   input  logic       erro_en,
   input  logic [3:0] erro_rodada,
   input  logic       acertou,
   input  logic       errou,
   input  logic       pronto,
   output logic       iniciar,
   output logic [3:0] botoes,
   output logic       fim,
   output logic       passou,
   output logic       falhou,
   output logic [3:0] db_rodada,
   output logic [3:0] db_estado
);

   localparam int M1   = (START_CYCLES > HOLD_CYCLES) ? START_CYCLES : HOLD_CYCLES;
   localparam int M2   = (M1 > GAP_CYCLES) ? M1 : GAP_CYCLES;
   localparam int MAXC = (M2 > TIMEOUT_CYCLES) ? M2 : TIMEOUT_CYCLES;
   localparam int TW   = (MAXC > 2) ? $clog2(MAXC) : 1;
   localparam logic [3:0] ULTIMA = 4'(N_JOGADAS - 1);

   logic [2:0]    estado, estado_n;
   logic [3:0]    rodada, rodada_n, jogada, jogada_n;
   logic          erro_en_r, erro_feito;
   logic [3:0]    erro_rodada_r;
   veredito_t     ver;
   logic          carga, zero, t_en;
   logic [TW-1:0] valor;
   logic          inicio, vai_fim, ok;
   logic          erro_atual, erro_prox;

   // erro_atual: the press in progress is the injected one; erro_prox: the press about to start is.
   assign erro_atual = erro_en_r && (erro_rodada_r == rodada)   && (jogada == rodada);
   assign erro_prox  = erro_en_r && (erro_rodada_r == rodada_n) && (jogada_n == rodada_n);
   assign t_en       = (estado != IDLE) && (estado != FIM);

   temporizador #(.W(TW)) u_tempo (
      .clock (clock),
      .reset (reset),
      .carga (carga),
      .en    (t_en),
      .valor (valor),
      .zero  (zero)
   );

   always_comb begin
      estado_n = estado;
      rodada_n = rodada;
      jogada_n = jogada;
      carga    = 1'b0;
      valor    = '0;
      inicio   = 1'b0;
      vai_fim  = 1'b0;
      ok       = 1'b0;
      case (estado)
         IDLE, FIM: if (comecar) begin
            inicio   = 1'b1;
            estado_n = INICIA;
            carga    = 1'b1;
            valor    = TW'(START_CYCLES - 1);
         end
         INICIA: if (zero) begin
            estado_n = ESPERA_INI;
            carga    = 1'b1;
            valor    = TW'(GAP_CYCLES - 1);
         end
         ESPERA_INI: if (zero) begin
            estado_n = PRESSIONA;
            rodada_n = 4'd0;
            jogada_n = 4'd0;
            carga    = 1'b1;
            valor    = TW'(HOLD_CYCLES - 1);
         end
         // errou while the wrong button is still held is early; pronto is always early here.
         PRESSIONA: if (pronto || errou) begin
            estado_n = FIM;
            vai_fim  = 1'b1;
         end else if (zero) begin
            estado_n = SOLTA;
            carga    = 1'b1;
            valor    = TW'(GAP_CYCLES - 1);
         end
         SOLTA: if (pronto || (errou && !erro_atual)) begin
            estado_n = FIM;
            vai_fim  = 1'b1;
         end else if (zero) begin
            carga = 1'b1;
            if (jogada < rodada) begin
               jogada_n = jogada + 4'd1;
               estado_n = PRESSIONA;
               valor    = TW'(HOLD_CYCLES - 1);
            end else if (erro_atual || rodada == ULTIMA) begin
               estado_n = AGUARDA;
               valor    = TW'(TIMEOUT_CYCLES - 1);
            end else begin
               rodada_n = rodada + 4'd1;
               jogada_n = 4'd0;
               estado_n = PRESSIONA;
               valor    = TW'(HOLD_CYCLES - 1);
            end
         end
         AGUARDA: if (pronto) begin
            estado_n = FIM;
            vai_fim  = 1'b1;
            ok       = erro_feito ? errou : acertou;
         end else if (zero) begin
            estado_n = FIM;
            vai_fim  = 1'b1;
         end
         default: estado_n = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado        <= IDLE;
         rodada        <= '0;
         jogada        <= '0;
         erro_en_r     <= 1'b0;
         erro_rodada_r <= '0;
         erro_feito    <= 1'b0;
         ver           <= '0;
         iniciar       <= 1'b0;
         botoes        <= '0;
      end else begin
         estado  <= estado_n;
         rodada  <= rodada_n;
         jogada  <= jogada_n;
         iniciar <= (estado_n == INICIA);
         if (estado_n == PRESSIONA)
            botoes <= erro_prox ? rot_esq(seq_valor(jogada_n)) : seq_valor(jogada_n);
         else
            botoes <= 4'b0000;
         if (inicio) begin
            erro_en_r     <= erro_en;
            erro_rodada_r <= erro_rodada;
            erro_feito    <= 1'b0;
            ver           <= '0;
         end else if (estado == SOLTA && estado_n == AGUARDA && erro_atual) begin
            erro_feito <= 1'b1;
         end
         if (vai_fim) begin
            ver.fim    <= 1'b1;
            ver.passou <= ok;
            ver.falhou <= ~ok;
         end
      end
   end

   assign fim       = ver.fim;
   assign passou    = ver.passou;
   assign falhou    = ver.falhou;
   assign db_rodada = rodada;
   assign db_estado = {1'b0, estado};

endmodule

// File: tb/tb_jogador_automatico.sv
// Directed bench for jogador_automatico: each task plays a scenario against a small game model.
module tb_jogador_automatico;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       comecar = 1'b0;
   logic       erro_en = 1'b0;
   logic [3:0] erro_rodada = 4'd0;
   logic       acertou = 1'b0;
   logic       errou = 1'b0;
   logic       pronto = 1'b0;
   logic       iniciar;
   logic [3:0] botoes;
   logic       fim, passou, falhou;
   logic [3:0] db_rodada, db_estado;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clock = ~clock;

   jogador_automatico dut (
      .clock       (clock),
      .reset       (reset),
      .comecar     (comecar),
      .erro_en     (erro_en),
      .erro_rodada (erro_rodada),
      .acertou     (acertou),
      .errou       (errou),
      .pronto      (pronto),
      .iniciar     (iniciar),
      .botoes      (botoes),
      .fim         (fim),
      .passou      (passou),
      .falhou      (falhou),
      .db_rodada   (db_rodada),
      .db_estado   (db_estado)
   );

   task start_run(input logic en, input logic [3:0] rod);
      @(negedge clock);
      erro_en     = en;
      erro_rodada = rod;
      comecar     = 1'b1;
      @(negedge clock);
      comecar     = 1'b0;
   endtask

   task wait_estado(input logic [3:0] s, input int max, output bit ok);
      int k;
      k = 0;
      while (db_estado !== s && k < max) begin
         @(negedge clock);
         k++;
      end
      ok = (db_estado === s);
   endtask

   task test_reset;
      repeat (3) @(negedge clock);
      n_cmp++; if (iniciar !== 1'b0) begin n_bad++; $display("FAIL reset_iniciar: got %b want 0", iniciar); end
      n_cmp++; if (botoes !== 4'b0000) begin n_bad++; $display("FAIL reset_botoes: got %b want 0000", botoes); end
      n_cmp++; if ({fim, passou, falhou} !== 3'b000) begin n_bad++; $display("FAIL reset_verdict: got %b want 000", {fim, passou, falhou}); end
      n_cmp++; if (db_estado !== 4'd0 || db_rodada !== 4'd0) begin n_bad++; $display("FAIL reset_db: got estado %0d rodada %0d want 0 0", db_estado, db_rodada); end
      reset = 1'b0;
   endtask

   task test_start;
      int hi, lo, pr;
      start_run(1'b0, 4'd0);
      hi = 0;
      while (iniciar === 1'b1 && hi < 20) begin hi++; @(negedge clock); end
      n_cmp++; if (hi != 5) begin n_bad++; $display("FAIL start_iniciar_len: got %0d want 5", hi); end
      lo = 0;
      while (botoes === 4'b0000 && iniciar === 1'b0 && lo < 20) begin lo++; @(negedge clock); end
      n_cmp++; if (lo != 10) begin n_bad++; $display("FAIL start_gap_len: got %0d want 10", lo); end
      n_cmp++; if (botoes !== 4'b0001) begin n_bad++; $display("FAIL start_first_press: got %b want 0001", botoes); end
      pr = 0;
      while (botoes === 4'b0001 && pr < 20) begin pr++; @(negedge clock); end
      n_cmp++; if (pr != 10) begin n_bad++; $display("FAIL start_hold_len: got %0d want 10", pr); end
   endtask

   task test_reset_mid;
      bit ok;
      wait_estado(4'd3, 100, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL rmid_reach_press: got estado %0d want 3", db_estado); end
      reset = 1'b1;
      @(negedge clock);
      n_cmp++; if (botoes !== 4'b0000 || iniciar !== 1'b0) begin n_bad++; $display("FAIL rmid_outputs: got botoes %b iniciar %b want 0000 0", botoes, iniciar); end
      n_cmp++; if (fim !== 1'b0 || db_estado !== 4'd0) begin n_bad++; $display("FAIL rmid_state: got fim %b estado %0d want 0 0", fim, db_estado); end
      reset = 1'b0;
   endtask

   task test_error_r3;
      logic [3:0] exp_p [10];
      logic [3:0] got [10];
      logic [3:0] prev;
      int np, k;
      exp_p = '{4'h1, 4'h1, 4'h2, 4'h1, 4'h2, 4'h4, 4'h1, 4'h2, 4'h4, 4'h1};
      start_run(1'b1, 4'd3);
      np = 0; k = 0; prev = 4'd0;
      while (fim !== 1'b1 && k < 3000) begin
         if (prev == 4'd0 && botoes != 4'd0) begin
            if (np < 10) got[np] = botoes;
            np++;
         end
         prev = botoes;
         if (db_estado == 4'd5) begin errou = 1'b1; pronto = 1'b1; end
         @(negedge clock);
         k++;
      end
      errou = 1'b0; pronto = 1'b0;
      n_cmp++; if (np != 10) begin n_bad++; $display("FAIL err3_press_count: got %0d want 10", np); end
      for (int i = 0; i < 10; i++) begin
         n_cmp++;
         if (i < np && got[i] !== exp_p[i]) begin n_bad++; $display("FAIL err3_press_%0d: got %b want %b", i, got[i], exp_p[i]); end
         else if (i >= np) begin n_bad++; $display("FAIL err3_press_%0d: got none want %b", i, exp_p[i]); end
      end
      n_cmp++; if ({fim, passou, falhou} !== 3'b110) begin n_bad++; $display("FAIL err3_verdict: got %b want 110", {fim, passou, falhou}); end
      n_cmp++; if (db_rodada !== 4'd3) begin n_bad++; $display("FAIL err3_rodada: got %0d want 3", db_rodada); end
   endtask

   task test_full_game;
      logic [3:0] prev, expv;
      int np, k, bad, er, ej, first_bad;
      start_run(1'b0, 4'd0);
      np = 0; k = 0; bad = 0; er = 0; ej = 0; first_bad = -1; prev = 4'd0;
      while (fim !== 1'b1 && k < 5000) begin
         if (prev == 4'd0 && botoes != 4'd0) begin
            expv = 4'b0001 << (ej % 4);
            if (botoes !== expv) begin bad++; if (first_bad < 0) first_bad = np; end
            np++;
            if (ej < er) ej++;
            else begin er++; ej = 0; end
         end
         prev = botoes;
         if (db_estado == 4'd5) begin acertou = 1'b1; pronto = 1'b1; end
         @(negedge clock);
         k++;
      end
      acertou = 1'b0; pronto = 1'b0;
      n_cmp++; if (np != 136) begin n_bad++; $display("FAIL full_press_count: got %0d want 136", np); end
      n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL full_press_values: got %0d wrong (first at %0d) want 0", bad, first_bad); end
      n_cmp++; if ({fim, passou, falhou} !== 3'b110) begin n_bad++; $display("FAIL full_verdict: got %b want 110", {fim, passou, falhou}); end
      n_cmp++; if (db_rodada !== 4'd15) begin n_bad++; $display("FAIL full_rodada: got %0d want 15", db_rodada); end
   endtask

   task test_timeout;
      bit ok;
      int k;
      start_run(1'b1, 4'd0);
      wait_estado(4'd3, 100, ok);
      n_cmp++; if (!ok || botoes !== 4'b0010) begin n_bad++; $display("FAIL tmo_error_press: got %b want 0010", botoes); end
      wait_estado(4'd5, 100, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL tmo_reach_wait: got estado %0d want 5", db_estado); end
      k = 0;
      while (falhou !== 1'b1 && k < 1100) begin @(negedge clock); k++; end
      n_cmp++; if (k != 1000) begin n_bad++; $display("FAIL tmo_latency: got %0d want 1000", k); end
      n_cmp++; if ({fim, passou} !== 2'b10) begin n_bad++; $display("FAIL tmo_verdict: got fim %b passou %b want 1 0", fim, passou); end
   endtask

   task test_early_error;
      int k;
      start_run(1'b1, 4'd3);
      k = 0;
      while (!(db_rodada == 4'd1 && botoes != 4'd0) && k < 500) begin @(negedge clock); k++; end
      n_cmp++; if (k >= 500) begin n_bad++; $display("FAIL early_reach_round1: got rodada %0d want 1", db_rodada); end
      errou = 1'b1;
      @(negedge clock);
      errou = 1'b0;
      n_cmp++; if ({fim, passou, falhou} !== 3'b101) begin n_bad++; $display("FAIL early_verdict: got %b want 101", {fim, passou, falhou}); end
      n_cmp++; if (db_estado !== 4'd6) begin n_bad++; $display("FAIL early_estado: got %0d want 6", db_estado); end
   endtask

   task test_restart;
      int hi;
      start_run(1'b0, 4'd0);
      n_cmp++; if ({fim, passou, falhou} !== 3'b000) begin n_bad++; $display("FAIL restart_clear: got %b want 000", {fim, passou, falhou}); end
      n_cmp++; if (iniciar !== 1'b1) begin n_bad++; $display("FAIL restart_iniciar: got %b want 1", iniciar); end
      // a second comecar while busy must not stretch or restart the pulse
      @(negedge clock);
      comecar = 1'b1;
      @(negedge clock);
      comecar = 1'b0;
      hi = 0;
      while (iniciar === 1'b1 && hi < 20) begin hi++; @(negedge clock); end
      n_cmp++; if (hi != 3) begin n_bad++; $display("FAIL busy_ignored: got %0d remaining iniciar cycles want 3", hi); end
      n_cmp++; if (db_estado !== 4'd2) begin n_bad++; $display("FAIL busy_estado: got %0d want 2", db_estado); end
   endtask

   initial begin
      test_reset;
      test_start;
      test_reset_mid;
      test_error_r3;
      test_full_game;
      test_timeout;
      test_early_error;
      test_restart;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
